alu_op_sequencer: RTL and testbench

//  Initiator side of the ALU result-select path: accepts operation requests via valid/ready,

---
 rtl/alu_op_sequencer_pkg.sv | 19 +
 rtl/alu_op_sequencer_settle_timer.sv | 37 +++
 rtl/alu_op_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants and types for the ALU result-select sequencer:
// select codes for the 5:1 result mux and the sequencer FSM state encoding.
package alu_op_sequencer_pkg;

    localparam int ALU_NUM_OPS = 5;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_NAND = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_settle_timer.sv
// Down-counter that measures the settle time of the result mux after a new
// select/operand set has been registered; zero flags the capture cycle.
module settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins over decrement; the counter parks at zero rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for the ALU result-select path: accepts a request, drives operands and
// select to the result mux, waits for the mux to settle, then returns the result.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int CTL_W   = 4,
    parameter int NUM_OPS = ALU_NUM_OPS,
    parameter int SETTLE  = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CTL_W-1:0] req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [CTL_W-1:0] alu_ctl,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [CNT_W-1:0] ops_done,
    output logic [CNT_W-1:0] err_count
);

    localparam int TIMER_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [CTL_W-1:0] alu_ctl_q, alu_ctl_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0] ops_done_q, ops_done_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic timer_load;
    logic timer_dec;
    logic timer_zero;
    logic op_legal;

    assign op_legal = ({1'b0, req_op} < (CTL_W+1)'(NUM_OPS));

    settle_timer #(
        .W (TIMER_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (TIMER_W'(SETTLE - 1)),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctl_d   = alu_ctl_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = rsp_valid_q;
        ops_done_d  = ops_done_q;
        err_count_d = err_count_q;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    alu_a_d = req_a;
                    alu_b_d = req_b;
                    // An illegal select never reaches the mux; answer with an error at once.
                    if (op_legal) begin
                        alu_ctl_d  = req_op;
                        timer_load = 1'b1;
                        state_d    = ST_SETTLE;
                    end else begin
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                        state_d = ST_RESP;
                    end
                end
            end
            ST_SETTLE: begin
                if (timer_zero) begin
                    rsp_data_d  = alu_out;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (ops_done_q != '1) begin
                        ops_done_d = ops_done_q + CNT_W'(1);
                    end
                    state_d = ST_RESP;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctl_q   <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            ops_done_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctl_q   <= alu_ctl_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            ops_done_q  <= ops_done_d;
            err_count_q <= err_count_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctl   = alu_ctl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign ops_done  = ops_done_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer; the ALU and result mux are
// modelled behaviourally and every response is compared with a transaction-level model.
module tb_alu_op_sequencer;

    localparam int WIDTH   = 32;
    localparam int CTL_W   = 4;
    localparam int NUM_OPS = 5;
    localparam int SETTLE  = 3;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int PERIOD  = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [CTL_W-1:0] req_op = '0;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [CTL_W-1:0] alu_ctl;
    logic [WIDTH-1:0] alu_out;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [CNT_W-1:0] ops_done;
    logic [CNT_W-1:0] err_count;

    int checkCount = 0;
    int errorCount = 0;

    int          expOps = 0;
    int          expErr = 0;
    logic [3:0]  expCtl = '0;
    logic        checkSpacing = 1'b0;
    longint      lastRspTime = 0;

    always #(PERIOD/2) clk = ~clk;

    alu_op_sequencer #(
        .WIDTH   (WIDTH),
        .CTL_W   (CTL_W),
        .NUM_OPS (NUM_OPS),
        .SETTLE  (SETTLE),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctl   (alu_ctl),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ops_done  (ops_done),
        .err_count (err_count)
    );

    // Reference ALU: the five result-mux inputs computed directly from the operands.
    function automatic logic [WIDTH-1:0] refAlu(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return ~(a & b);
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out = refAlu(alu_ctl, alu_a, alu_b);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full request/response transaction; holdCycles keeps rsp_ready low while a
    // stray request is pulsed, then the response is consumed.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int holdCycles);
        logic        legal;
        logic [31:0] expData;
        int          waitEdges;
        legal   = (op < NUM_OPS);
        expData = legal ? refAlu(op, a, b) : 32'd0;
        @(negedge clk);
        checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_op    = 4'($urandom);
        if (legal) expCtl = op;
        checkOutput("alu_a", alu_a, a);
        checkOutput("alu_b", alu_b, b);
        checkOutput("alu_ctl", {28'd0, alu_ctl}, {28'd0, expCtl});
        waitEdges = 0;
        while (!rsp_valid && waitEdges < 40) begin
            checkOutput("req_ready_busy", {31'd0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
            waitEdges++;
        end
        if (!rsp_valid) begin
            checkOutput("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        checkOutput("latency", waitEdges, legal ? SETTLE : 0);
        if (checkSpacing) checkOutput("spacing", 32'(($time - lastRspTime) / PERIOD), SETTLE + 2);
        lastRspTime = $time;
        if (legal) expOps = (expOps < CNT_MAX) ? expOps + 1 : CNT_MAX;
        else       expErr = (expErr < CNT_MAX) ? expErr + 1 : CNT_MAX;
        checkOutput("rsp_data", rsp_data, expData);
        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, ~legal});
        checkOutput("ops_done", 32'(ops_done), expOps);
        checkOutput("err_count", 32'(err_count), expErr);
        if (holdCycles > 0) begin
            rsp_ready = 1'b0;
            for (int i = 0; i < holdCycles; i++) begin
                @(negedge clk);
                req_valid = (i == 2);
                req_op    = 4'($urandom_range(0, 4));
                req_a     = $urandom;
                checkOutput("hold_valid", {31'd0, rsp_valid}, 32'd1);
                checkOutput("hold_data", rsp_data, expData);
                checkOutput("hold_ready", {31'd0, req_ready}, 32'd0);
                checkOutput("hold_alu_a", alu_a, a);
            end
            @(negedge clk);
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rsp_released", {31'd0, rsp_valid}, 32'd0);
        checkOutput("back_to_idle", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #1;
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_alu_ctl", {28'd0, alu_ctl}, 32'd0);
        checkOutput("reset_ops_done", 32'(ops_done), 32'd0);
        checkOutput("reset_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed: xor, illegal, backpressure");
        applyStimulus(4'd2, 32'h0000_00F0, 32'h0000_000F, 0);
        applyStimulus(4'd7, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        applyStimulus(4'd1, 32'h0000_0010, 32'h0000_0020, 10);

        $display("[TB] back-to-back ops 0,1,4");
        applyStimulus(4'd0, 32'hFFFF_FFFF, 32'h0000_0002, 0);
        checkSpacing = 1'b1;
        applyStimulus(4'd1, 32'h8000_0000, 32'h0000_0001, 0);
        applyStimulus(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        checkSpacing = 1'b0;

        $display("[TB] reset during settle");
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'd3;
        req_a     = 32'hFFFF_FFFE;
        req_b     = 32'h0000_0005;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        expOps = 0;
        expErr = 0;
        expCtl = '0;
        checkOutput("rst_alu_a", alu_a, 32'd0);
        checkOutput("rst_alu_ctl", {28'd0, alu_ctl}, 32'd0);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        checkOutput("rst_ops_done", 32'(ops_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
        end
        applyStimulus(4'd3, 32'hFFFF_FFFE, 32'h0000_0005, 0);

        $display("[TB] random transactions");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(4'($urandom_range(0, 9)), $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("[TB] counter saturation");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(4'($urandom_range(0, 4)), $urandom, $urandom, 0);
            applyStimulus(4'($urandom_range(5, 15)), $urandom, $urandom, 0);
        end
        checkOutput("ops_saturated", 32'(ops_done), CNT_MAX);
        checkOutput("err_saturated", 32'(err_count), CNT_MAX);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
